// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment scan driver.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef enum logic {
        BLANK,
        SHOW
    } seg_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed scan driver for a common-anode seven-segment display, advancing one digit per
// resynchronised clk_1K edge with a blanking gap between digits and per-frame snapshotting.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter bit          LZ_BLANK     = 1'b0
) (
    input  logic                  clk_1M,
    input  logic                  reset,
    input  logic                  clk_1K,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BLANK_CYCLES - 1);

    logic                k1_q, k2_q, k3_q;
    logic                tick, wrap;
    seg_state_e          state_q, state_d;
    logic [CntW-1:0]     blank_cnt_q, blank_cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d, dec_seg;
    logic                dp_d;
    logic [3:0]          nibble;
    logic [DIGITS-1:0]   lz;
    logic                all_zero;

    // k1/k2 form the synchroniser, k3 holds the previous level for edge detection.
    always_ff @(posedge clk_1M or negedge reset) begin
        if (!reset) begin
            k1_q <= 1'b0;
            k2_q <= 1'b0;
            k3_q <= 1'b0;
        end else begin
            k1_q <= clk_1K;
            k2_q <= k1_q;
            k3_q <= k2_q;
        end
    end

    assign tick = k2_q & ~k3_q;
    assign wrap = tick && (idx_q == IdxLast);

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_dp_d   = snap_dp_q;
        if (tick) begin
            state_d     = BLANK;
            blank_cnt_d = '0;
            idx_d       = wrap ? '0 : idx_q + 1'b1;
            if (wrap) begin
                snap_data_d = data;
                snap_dp_d   = dp_mask;
            end
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (blank_cnt_q == CntLast) begin
                        state_d = SHOW;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                SHOW: ;
            endcase
        end
    end

    assign nibble = snap_data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex_i (nibble),
        .seg_o (dec_seg)
    );

    // lz[i] is set when snapshot nibbles i..DIGITS-1 are all zero.
    always_comb begin
        lz       = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (snap_data_q[4*i +: 4] == 4'h0);
            lz[i]    = all_zero;
        end
    end

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (enable && (state_q == SHOW)) begin
            an_d[idx_q] = 1'b0;
            seg_d       = (LZ_BLANK && (idx_q != '0) && lz[idx_q]) ? SEG_OFF : dec_seg;
            dp_d        = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_1M or negedge reset) begin
        if (!reset) begin
            state_q     <= BLANK;
            blank_cnt_q <= '0;
            idx_q       <= '0;
            snap_data_q <= '0;
            snap_dp_q   <= '0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            idx_q       <= idx_d;
            snap_data_q <= snap_data_d;
            snap_dp_q   <= snap_dp_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
        end
    end

endmodule
